// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and access-geometry helpers shared by the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 4'h1 : f3[1:0] == 2'b01 ? 4'h3 : 4'hF;
  endfunction
  // true when offset + size runs past the end of the 32-bit word
  function automatic logic crosses(input logic [1:0] off, input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 1'b0 : f3[1:0] == 2'b01 ? off == 2'd3 : off != 2'd0;
  endfunction
  function automatic logic legal(input logic wen, input logic [2:0] f3);
    return f3 == F3_B || f3 == F3_H || f3 == F3_W || (!wen && (f3 == F3_BU || f3 == F3_HU));
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane shift and strobes for both word halves, load extract with sign/zero extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [3:0]  strb0,
  output logic [3:0]  strb1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] rdata
);
  logic [4:0] sh;
  logic [31:0] w;
  always_comb begin
    sh = {off, 3'b000};
    {strb1, strb0} = {4'b0000, size_mask(funct3)} << off;
    {wdata1, wdata0} = {32'b0, wdata} << sh;
    w = 32'({hi, lo} >> sh);
    rdata = funct3 == F3_B  ? {{24{w[7]}}, w[7:0]} :
            funct3 == F3_H  ? {{16{w[15]}}, w[15:0]} :
            funct3 == F3_BU ? {24'b0, w[7:0]} :
            funct3 == F3_HU ? {16'b0, w[15:0]} : w;
  end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit driving a word-aligned RAM port, splitting word-crossing accesses
module lsu
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
);
  state_t state, nxt;
  logic wen_r, err_r, bad, acc;
  logic [2:0] f3_r;
  logic [31:0] addr_r, wdata_r, lo, hi, base, ld_data, wdata0, wdata1;
  logic [3:0] strb0, strb1;
  lsu_align u_align (
    .off(addr_r[1:0]), .funct3(f3_r), .wdata(wdata_r), .lo(lo), .hi(hi),
    .strb0(strb0), .strb1(strb1), .wdata0(wdata0), .wdata1(wdata1), .rdata(ld_data)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      wen_r <= 1'b0;
      err_r <= 1'b0;
      f3_r <= 3'b000;
      addr_r <= 32'b0;
      wdata_r <= 32'b0;
      lo <= 32'b0;
      hi <= 32'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        wen_r <= req_wen;
        err_r <= bad;
        f3_r <= req_funct3;
        addr_r <= req_addr;
        wdata_r <= req_wdata;
        lo <= 32'b0;
        hi <= 32'b0;
      end
      if (state == ACC0 && !wen_r) lo <= mem_rdata;
      if (state == ACC1 && !wen_r) hi <= mem_rdata;
    end
  end
  always_comb begin
    bad = !legal(req_wen, req_funct3) || (!ALLOW_MISALIGNED && crosses(req_addr[1:0], req_funct3));
    nxt = state == IDLE ? (req_valid ? (bad ? RESP : ACC0) : IDLE) :
          state == ACC0 ? (crosses(addr_r[1:0], f3_r) ? ACC1 : RESP) :
          state == ACC1 ? RESP : IDLE;
    base = {addr_r[31:2], 2'b00};
    acc = state == ACC0 || state == ACC1;
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    rsp_err = state == RESP && err_r;
    rsp_rdata = state == RESP && !wen_r && !err_r ? ld_data : 32'b0;
    // reset gates the write strobe combinationally so an access cut by reset never lands
    mem_wen = reset && acc && wen_r;
    mem_addr = state == ACC0 ? base : state == ACC1 ? base + 32'd4 : 32'b0;
    mem_wstrb = state == ACC0 ? strb0 : state == ACC1 ? strb1 : 4'b0;
    mem_wdata = state == ACC0 ? wdata0 : state == ACC1 ? wdata1 : 32'b0;
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: vector table, directed corner sequences and randomized traffic against a byte-level memory model
module tb_lsu;
  logic clk = 1'b0, reset = 1'b0, req_valid = 1'b0, req_wen = 1'b0;
  logic [2:0] req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
  logic req_ready, rsp_valid, rsp_err, mem_wen;
  logic [31:0] rsp_rdata, mem_wdata, mem_addr, mem_rdata;
  logic [3:0] mem_wstrb;
  logic [31:0] ram [256];
  logic [7:0] mb [1024];
  logic pre_en = 1'b0;
  logic [7:0] pre_idx = 8'b0;
  logic [31:0] pre_data = 32'b0;
  logic c_wen [1:8];
  logic [31:0] c_addr [1:8], c_wdata [1:8];
  logic [3:0] c_strb [1:8];
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic wen; logic [2:0] f3; logic [31:0] addr, wdata, rdata; logic err; int lat;
  } vec_t;
  vec_t tv [11];

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = ram[mem_addr[9:2]];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (pre_en) ram[pre_idx] <= pre_data;
    else if (mem_wen) ram[mem_addr[9:2]] <= merge(ram[mem_addr[9:2]], mem_wdata, mem_wstrb);
  end

  function automatic int sz(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
  endfunction
  function automatic logic illegal(input logic wen, input logic [2:0] f3);
    return f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (wen && f3[2]);
  endfunction
  function automatic int exp_lat(input logic wen, input logic [2:0] f3, input logic [31:0] a);
    return illegal(wen, f3) ? 1 : (int'(a[1:0]) + sz(f3) > 4 ? 3 : 2);
  endfunction
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v, p;
    v = 32'b0;
    for (int i = 0; i < sz(f3); i++) begin
      p = a + 32'(i);
      v[8*i +: 8] = mb[p[9:0]];
    end
    if (!f3[2] && sz(f3) < 4 && v[8*sz(f3)-1]) v = v | ~((32'd1 << 8*sz(f3)) - 32'd1);
    return v;
  endfunction
  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] p;
    for (int i = 0; i < sz(f3); i++) begin
      p = a + 32'(i);
      mb[p[9:0]] = d[8*i +: 8];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    pre_en = 1'b1;
    pre_idx = a[9:2];
    pre_data = w;
    for (int i = 0; i < 4; i++) mb[{a[9:2], 2'(i)}] = w[8*i +: 8];
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_wen = wen;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr = $urandom;
  endtask

  task automatic collect(output int lat, output logic [31:0] rd, output logic er);
    lat = 0;
    rd = 'x;
    er = 1'bx;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      c_wen[n] = mem_wen;
      c_addr[n] = mem_addr;
      c_strb[n] = mem_wstrb;
      c_wdata[n] = mem_wdata;
      if (rsp_valid) begin
        lat = n;
        rd = rsp_rdata;
        er = rsp_err;
      end
    end
  endtask

  task automatic txn(input logic wen, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic er);
    issue(wen, f3, a, d);
    collect(lat, rd, er);
    if (wen && !illegal(wen, f3)) model_store(f3, a, d);
  endtask

  initial begin
    int lat;
    logic [31:0] rd, a, d, e_rd;
    logic er, wen;
    logic [2:0] f3;
    for (int i = 0; i < 256; i++) preload(32'(i) << 2, $urandom);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    preload(32'hFC, 32'hAABBCCDD);
    preload(32'h100, 32'h80FF7F01);
    preload(32'h104, 32'h55667788);
    tv[0]  = '{1'b0, 3'b000, 32'h102, 32'h0, 32'hFFFFFFFF, 1'b0, 2};
    tv[1]  = '{1'b0, 3'b100, 32'h102, 32'h0, 32'h000000FF, 1'b0, 2};
    tv[2]  = '{1'b0, 3'b001, 32'h100, 32'h0, 32'h00007F01, 1'b0, 2};
    tv[3]  = '{1'b0, 3'b010, 32'h0FE, 32'h0, 32'h7F01AABB, 1'b0, 3};
    tv[4]  = '{1'b0, 3'b101, 32'h103, 32'h0, 32'h00008880, 1'b0, 3};
    tv[5]  = '{1'b0, 3'b001, 32'h101, 32'h0, 32'hFFFFFF7F, 1'b0, 2};
    tv[6]  = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h8880FF7F, 1'b0, 3};
    tv[7]  = '{1'b0, 3'b000, 32'h100, 32'h0, 32'h00000001, 1'b0, 2};
    tv[8]  = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h00000000, 1'b1, 1};
    tv[9]  = '{1'b1, 3'b100, 32'h100, 32'h55, 32'h00000000, 1'b1, 1};
    tv[10] = '{1'b0, 3'b111, 32'h100, 32'h0, 32'h00000000, 1'b1, 1};
    foreach (tv[i]) begin
      txn(tv[i].wen, tv[i].f3, tv[i].addr, tv[i].wdata, lat, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tv[i].err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tv[i].lat));
    end

    txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat, rd, er);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_wen0", 32'(c_wen[1]), 32'd1);
    chk("sw_addr0", c_addr[1], 32'h100);
    chk("sw_strb0", 32'(c_strb[1]), 32'hF);
    chk("sw_wdata0", c_wdata[1], 32'hDEADBEEF);
    chk("sw_resp_wen", 32'(c_wen[2]), 32'd0);
    chk("sw_ram", ram[8'h40], 32'hDEADBEEF);

    txn(1'b1, 3'b000, 32'h103, 32'h000000AB, lat, rd, er);
    chk("sb_lat", 32'(lat), 32'd2);
    chk("sb_wen0", 32'(c_wen[1]), 32'd1);
    chk("sb_strb0", 32'(c_strb[1]), 32'h8);
    chk("sb_wdata0", c_wdata[1], 32'hAB000000);

    preload(32'h100, 32'h11223344);
    txn(1'b0, 3'b010, 32'hFE, 32'h0, lat, rd, er);
    chk("lw_x_lat", 32'(lat), 32'd3);
    chk("lw_x_addr0", c_addr[1], 32'hFC);
    chk("lw_x_addr1", c_addr[2], 32'h100);
    chk("lw_x_wen0", 32'(c_wen[1]), 32'd0);
    chk("lw_x_rdata", rd, 32'h3344AABB);

    txn(1'b1, 3'b001, 32'hFFFFFFFF, 32'h1234, lat, rd, er);
    chk("sh_wrap_lat", 32'(lat), 32'd3);
    chk("sh_wrap_wen0", 32'(c_wen[1]), 32'd1);
    chk("sh_wrap_addr0", c_addr[1], 32'hFFFFFFFC);
    chk("sh_wrap_strb0", 32'(c_strb[1]), 32'h8);
    chk("sh_wrap_wdata0", c_wdata[1], 32'h34000000);
    chk("sh_wrap_wen1", 32'(c_wen[2]), 32'd1);
    chk("sh_wrap_addr1", c_addr[2], 32'h0);
    chk("sh_wrap_strb1", 32'(c_strb[2]), 32'h1);
    chk("sh_wrap_wdata1", c_wdata[2], 32'h12);

    txn(1'b1, 3'b011, 32'h100, 32'h77, lat, rd, er);
    chk("bad_f3_lat", 32'(lat), 32'd1);
    chk("bad_f3_err", 32'(er), 32'd1);
    chk("bad_f3_wen", 32'(c_wen[1]), 32'd0);
    chk("bad_f3_rdata", rd, 32'd0);

    preload(32'h180, 32'h11111111);
    issue(1'b1, 3'b010, 32'h180, 32'hCAFEBABE);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_acc0_wen", 32'(mem_wen), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_acc0_ready", 32'(req_ready), 32'd1);
    chk("rst_acc0_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_acc0_ram", ram[8'h60], 32'h11111111);

    preload(32'h1FC, 32'h44444444);
    preload(32'h200, 32'h55555555);
    issue(1'b1, 3'b010, 32'h1FE, 32'hCAFEF00D);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_acc1_wen", 32'(mem_wen), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_store(3'b001, 32'h1FE, 32'hF00D);
    chk("rst_acc1_lo", ram[8'h7F], 32'hF00D4444);
    chk("rst_acc1_hi", ram[8'h80], 32'h55555555);

    for (int k = 0; k < 300; k++) begin
      wen = 1'($urandom);
      f3 = $urandom_range(0, 9) == 0 ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (!wen && $urandom_range(0, 2) == 0) f3 = f3 | 3'b100;
      a = $urandom_range(0, 9) == 0 ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 1023));
      d = $urandom;
      e_rd = (wen || illegal(wen, f3)) ? 32'd0 : model_load(f3, a);
      txn(wen, f3, a, d, lat, rd, er);
      chk($sformatf("rnd%0d_rdata", k), rd, e_rd);
      chk($sformatf("rnd%0d_err", k), 32'(er), 32'(illegal(wen, f3)));
      chk($sformatf("rnd%0d_lat", k), 32'(lat), 32'(exp_lat(wen, f3, a)));
    end
    @(negedge clk);
    for (int w = 0; w < 256; w++)
      chk($sformatf("ram_word%0d", w), ram[w], {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
